dcache_wt: RTL and testbench
============================

// Module: dcache_wt
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache. Sits downstream of the datapath
//  memory port (Address/WriteData/ReadData) and upstream of a slow backing data memory.
//  Serves read hits in zero cycles. Stalls the core on read misses and on every store until
//  the backing memory acknowledges.
// PARAMETERS
//  NBITS   8  data/address width; word addressing uses Address[NBITS-1:2]
//  NLINES  4  cache lines, one word per line, power of 2; IDX=$clog2(NLINES) < NBITS-2
// PORTS
//  clock      in   1           clock, rising edge
//  reset      in   1           synchronous, active-high
//  MemRead    in   1           load request from controller
//  MemWrite   in   1           store request from controller
//  Address    in   NBITS-2     word address [NBITS-1:2] from datapath
//  WriteData  in   NBITS       store data from datapath
//  ReadData   out  NBITS       load data to datapath (combinational)
//  Stall      out  1           freeze PC/regfile write while 1 (combinational)
//  mem_req    out  1           backing-memory request, registered
//  mem_we     out  1           1 = write, 0 = read; valid while mem_req
//  mem_addr   out  NBITS-2     latched word address
//  mem_wdata  out  NBITS       latched store data
//  mem_rdata  in   NBITS       fill data, valid with mem_ack
//  mem_ack    in   1           one-cycle completion pulse
//  hit_cnt    out  16          read-hit counter, saturating
//  miss_cnt   out  16          read-miss counter, saturating
// BEHAVIOUR
//  Address split: idx = Address[IDX+1:2], tag = Address[NBITS-1:IDX+2].
//  hit = valid[idx] & (tag_ram[idx] == tag).
//  Line storage: valid bit, tag, data.
//  Reset:
//    valid cleared; state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
//    counters=0. ReadData=0 and Stall=0 right after reset.
//  FSM states: IDLE, RMISS, WR, WDONE.
//  IDLE:
//    MemWrite (priority if MemRead also 1):
//      Stall=1; latch addr/data; mem_req<=1, mem_we<=1; ->WR.
//    MemRead & hit:
//      ReadData=data[idx], Stall=0; hit_cnt++; stay IDLE.
//    MemRead & ~hit:
//      Stall=1; latch addr; mem_req<=1, mem_we<=0; miss_cnt++; ->RMISS.
//    Otherwise: ReadData=0, Stall=0.
//  RMISS:
//    Stall=1; mem_req held, address stable.
//    On mem_ack: write line[idx] = {valid=1, tag, mem_rdata} (evicts conflicting line);
//    mem_req<=0; ->IDLE. The replayed read then hits the cycle after ack.
//    Miss latency = ack cycle + 1.
//  WR:
//    Stall=1; mem_req held.
//    On mem_ack: if the latched address hits, update data[idx]; if it misses, no
//    allocation. mem_req<=0; ->WDONE.
//  WDONE:
//    Stall=0 for exactly one cycle so the core retires the store; requests ignored; ->IDLE.
//  mem_ack outside RMISS/WR is ignored. mem_ack in the same cycle mem_req rises
//  (zero-latency) is legal.
//  Counters saturate at 16'hFFFF. A hit in the replay cycle after a fill is not counted.
//  Reset mid-transaction: abandon immediately; mem_req drops next edge; the backing memory
//  must tolerate an abandoned request.
// TESTING
//  1. Read A=0x05 after reset, memory returns 0x3C after 2 cycles
//     -> Stall for 3 cycles; next cycle ReadData=0x3C; miss_cnt=1.
//     Second read of A=0x05 -> Stall=0, ReadData=0x3C, hit_cnt=1.
//  2. Store 0x77 to cached A=0x05
//     -> mem_req/mem_we=1, mem_addr=0x05, mem_wdata=0x77; Stall until ack, then one
//     WDONE cycle. Read A=0x05 then hits with 0x77.
//  3. Store 0x11 to uncached A=0x09
//     -> memory written; a following read of 0x09 misses (no allocate).
//  4. Conflict: read 0x01, then 0x05 (same idx), then 0x01
//     -> three misses; each fill overwrites the line.
//  5. Assert reset while in RMISS
//     -> next cycle mem_req=0, Stall=0, all lines invalid; a late mem_ack is ignored.
//  6. Hold mem_ack=1 in the same cycle mem_req rises
//     -> fill is accepted; total stall = 2 cycles.

Source files
------------

// File: rtl/dcache_wt_if.sv
// -----------------------------------------------------------------------------
// dcache_wt_if.sv
// Bus bundles for the write-through data cache.
//
// dcache_core_if : datapath <-> cache memory port.
//   master (core side)  drives MemRead, MemWrite, Address, WriteData;
//                       receives ReadData, Stall.
//   slave  (cache side) the reverse.
//   Handshake: a request (MemRead or MemWrite) is held by the core for every
//   cycle in which Stall=1; the request completes in the first cycle it is
//   sampled with Stall=0 (load data valid on ReadData in that cycle).
//
// dcache_mem_if : cache <-> backing data memory.
//   master (cache side)  drives mem_req, mem_we, mem_addr, mem_wdata;
//                        receives mem_rdata, mem_ack.
//   slave  (memory side) the reverse.
//   Handshake: mem_req is held with stable mem_we/mem_addr/mem_wdata until the
//   memory returns a single-cycle mem_ack (mem_rdata valid with it). The ack
//   may come in the first cycle mem_req is high. A request may be abandoned by
//   reset; the memory must tolerate that.
// -----------------------------------------------------------------------------
interface dcache_core_if #(
  parameter int NBITS = 8
);
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-3:0] Address;
  logic [NBITS-1:0] WriteData;
  logic [NBITS-1:0] ReadData;
  logic             Stall;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Stall
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Stall
  );
endinterface

interface dcache_mem_if #(
  parameter int NBITS = 8
);
  logic             mem_req;
  logic             mem_we;
  logic [NBITS-3:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic [NBITS-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_wt.sv
// -----------------------------------------------------------------------------
// dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per
// line. Read hits are served combinationally with no stall; read misses and
// all stores stall the core until the backing memory acknowledges.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   core (slave)    MemRead/MemWrite/Address/WriteData in, ReadData/Stall out
//                   (ReadData and Stall are combinational)
//   mem  (master)   registered mem_req/mem_we/mem_addr/mem_wdata out,
//                   mem_rdata/mem_ack in
//   hit_cnt         saturating count of counted read hits
//   miss_cnt        saturating count of read misses
//   state_dbg       current controller state (IDLE/RMISS/WR/WDONE = 0..3)
//
// Address is the word address (byte address bits [NBITS-1:2]); its low IDX
// bits select the line, the remaining bits form the tag. NLINES must be a
// power of two and at least 2.
// -----------------------------------------------------------------------------
module dcache_wt #(
  parameter int NBITS  = 8,
  parameter int NLINES = 4
) (
  input  logic         clock,
  input  logic         reset,
  dcache_core_if.slave core,
  dcache_mem_if.master mem,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt,
  output logic [1:0]   state_dbg
);

  localparam int AW  = NBITS - 2;
  localparam int IDX = $clog2(NLINES);
  localparam int TW  = AW - IDX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WR    = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Line storage
  logic [NLINES-1:0] valid_q, valid_d;
  logic [TW-1:0]     tag_q  [NLINES];
  logic [TW-1:0]     tag_d  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];
  logic [NBITS-1:0]  data_d [NLINES];

  // Backing-memory request registers
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_wdata_q, mem_wdata_d;

  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // High in the cycle right after a fill: the core replays its load then and
  // that hit must not be counted a second time.
  logic replay_q, replay_d;

  // Lookup for the incoming core request
  logic [IDX-1:0] req_idx;
  logic [TW-1:0]  req_tag;
  logic           req_hit;

  // Lookup for the latched request (fill target / store update)
  logic [IDX-1:0] lat_idx;
  logic [TW-1:0]  lat_tag;
  logic           lat_hit;

  assign req_idx = core.Address[IDX-1:0];
  assign req_tag = core.Address[AW-1:IDX];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign lat_idx = mem_addr_q[IDX-1:0];
  assign lat_tag = mem_addr_q[AW-1:IDX];
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  // ---------------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      replay_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      replay_q    <= replay_d;
    end
  end

  // Tag and data arrays need no reset: the valid bits guard them.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Stores win over loads when both are requested.
        if (core.MemWrite)                 state_d = WR;
        else if (core.MemRead && !req_hit) state_d = RMISS;
      end
      RMISS:   if (mem.mem_ack) state_d = IDLE;
      WR:      if (mem.mem_ack) state_d = WDONE;
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Core-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    core.Stall    = 1'b0;
    core.ReadData = '0;
    case (state_q)
      IDLE: begin
        if (core.MemWrite) begin
          core.Stall = 1'b1;
        end else if (core.MemRead) begin
          if (req_hit) core.ReadData = data_q[req_idx];
          else         core.Stall    = 1'b1;
        end
      end
      RMISS, WR: core.Stall = 1'b1;
      // WDONE: one unstalled cycle so the core retires the store.
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request registers, line updates and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    replay_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (core.MemWrite) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = core.Address;
          mem_wdata_d = core.WriteData;
        end else if (core.MemRead) begin
          if (req_hit) begin
            if (!replay_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = core.Address;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      RMISS: begin
        if (mem.mem_ack) begin
          // Fill overwrites whatever line sat at this index.
          valid_d[lat_idx] = 1'b1;
          tag_d[lat_idx]   = lat_tag;
          data_d[lat_idx]  = mem.mem_rdata;
          mem_req_d        = 1'b0;
          replay_d         = 1'b1;
        end
      end
      WR: begin
        if (mem.mem_ack) begin
          // Write-through without allocation: only refresh a resident line.
          if (lat_hit) data_d[lat_idx] = mem_wdata_q;
          mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dcache_wt.sv
// -----------------------------------------------------------------------------
// tb_dcache_wt.sv
// Self-checking bench for dcache_wt. The reference keeps, per line index, the
// full word address currently resident (or -1) and its data, plus a reference
// copy of backing memory; expected stall lengths, read data and counters are
// derived from those. The backing memory itself is modelled by the bench and
// is written only through the DUT's memory port.
// -----------------------------------------------------------------------------
module tb_dcache_wt;
  localparam int NBITS  = 8;
  localparam int NLINES = 4;
  localparam int AW     = NBITS - 2;
  localparam int MSIZE  = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  state_dbg;

  dcache_core_if #(.NBITS(NBITS)) core_if ();
  dcache_mem_if  #(.NBITS(NBITS)) mem_if ();

  dcache_wt #(.NBITS(NBITS), .NLINES(NLINES)) dut (
    .clock     (clock),
    .reset     (reset),
    .core      (core_if),
    .mem       (mem_if),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [NBITS-1:0] bmem    [MSIZE];  // backing memory, written via DUT port
  logic [NBITS-1:0] ref_mem [MSIZE];  // what memory should hold
  int               line_addr [NLINES];
  logic [NBITS-1:0] line_data [NLINES];
  int               exp_hits;
  int               exp_miss;
  logic [NBITS-1:0] exp_q [$];

  task automatic model_clear();
    for (int i = 0; i < NLINES; i++) begin
      line_addr[i] = -1;
      line_data[i] = '0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_cycle();
    @(posedge clock); #1;
    core_if.MemRead   = 1'b0;
    core_if.MemWrite  = 1'b0;
    mem_if.mem_ack    = 1'b0;
    #4;
  endtask

  // One core access held until the cache stops stalling. lat = number of
  // mem_req cycles the memory lets pass before acking.
  task automatic access(input bit wr, input logic [AW-1:0] a,
                        input logic [NBITS-1:0] wd, input int lat, input bit both);
    int  li;
    bit  hit;
    int  stalls;
    int  reqn;
    bit  released;
    li  = int'(a) % NLINES;
    hit = (line_addr[li] == int'(a));

    @(posedge clock); #1;
    mem_if.mem_ack     = 1'b0;
    core_if.MemRead    = !wr || both;
    core_if.MemWrite   = wr;
    core_if.Address    = a;
    core_if.WriteData  = wd;
    #4;

    if (!wr && hit) begin
      exp_q.push_back(line_data[li]);
      n_checks++;
      if (core_if.Stall !== 1'b0 || core_if.ReadData !== exp_q[0]) begin
        n_fail++;
        $display("FAIL read_hit a=%h: stall=%b data=%h, required stall=0 data=%h",
                 a, core_if.Stall, core_if.ReadData, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_hits++;
      return;
    end

    n_checks++;
    if (core_if.Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL first_stall a=%h wr=%0d: stall=%b required 1", a, wr, core_if.Stall);
    end

    stalls   = 1;
    reqn     = 0;
    released = 1'b0;
    for (int c = 0; c < 40 && !released; c++) begin
      @(posedge clock); #1;
      mem_if.mem_ack = 1'b0;
      if (mem_if.mem_req === 1'b1) begin
        reqn++;
        if (reqn == 1) begin
          n_checks++;
          if (mem_if.mem_we !== wr || mem_if.mem_addr !== a ||
              (wr && mem_if.mem_wdata !== wd)) begin
            n_fail++;
            $display("FAIL mem_request: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, wr, a, wd);
          end
        end
        if (reqn == lat + 1) begin
          mem_if.mem_ack = 1'b1;
          if (mem_if.mem_we) bmem[mem_if.mem_addr] = mem_if.mem_wdata;
          else               mem_if.mem_rdata      = bmem[mem_if.mem_addr];
        end
      end
      #4;
      if (core_if.Stall === 1'b1) stalls++;
      else                        released = 1'b1;
    end

    n_checks++;
    if (!released || stalls != lat + 2) begin
      n_fail++;
      $display("FAIL stall_length a=%h wr=%0d: stalled %0d cycles (released=%0d), required %0d",
               a, wr, stalls, released, lat + 2);
    end

    if (wr) begin
      ref_mem[a] = wd;
      if (hit) line_data[li] = wd;
    end else begin
      exp_miss++;
      line_addr[li] = int'(a);
      line_data[li] = ref_mem[a];
      exp_q.push_back(ref_mem[a]);
      n_checks++;
      if (core_if.ReadData !== exp_q[0]) begin
        n_fail++;
        $display("FAIL replay_data a=%h: got %h required %h", a, core_if.ReadData, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    mem_if.mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #4;
    n_checks++;
    if (core_if.Stall !== 1'b0 || core_if.ReadData !== '0 || mem_if.mem_req !== 1'b0 ||
        mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== '0 || mem_if.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b rdata=%h req=%b we=%b addr=%h wdata=%h, required all 0",
               core_if.Stall, core_if.ReadData, mem_if.mem_req, mem_if.mem_we,
               mem_if.mem_addr, mem_if.mem_wdata);
    end
    n_checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
    end
    model_clear();
  endtask

  task automatic test_read_miss_then_hit();
    bmem[5] = 8'h3C;
    ref_mem[5] = 8'h3C;
    access(1'b0, 6'h05, 8'h00, 1, 1'b0);  // three stall cycles
    idle_cycle();
    n_checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL first_miss_counters: hit=%0d miss=%0d required 0 1", hit_cnt, miss_cnt);
    end
    access(1'b0, 6'h05, 8'h00, 0, 1'b0);  // hit
    idle_cycle();
    n_checks++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL second_read_counters: hit=%0d miss=%0d required 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_store_hit();
    access(1'b1, 6'h05, 8'h77, 2, 1'b0);
    idle_cycle();
    n_checks++;
    if (bmem[5] !== 8'h77) begin
      n_fail++;
      $display("FAIL store_hit_memory: mem[05]=%h required 77", bmem[5]);
    end
    access(1'b0, 6'h05, 8'h00, 0, 1'b0);  // hit with the new value
    idle_cycle();
  endtask

  task automatic test_store_miss();
    access(1'b1, 6'h09, 8'h11, 0, 1'b0);
    idle_cycle();
    n_checks++;
    if (bmem[9] !== 8'h11) begin
      n_fail++;
      $display("FAIL store_miss_memory: mem[09]=%h required 11", bmem[9]);
    end
    access(1'b0, 6'h09, 8'h00, 1, 1'b0);  // no allocate, so a miss
    idle_cycle();
    n_checks++;
    if (miss_cnt !== 16'(exp_miss) || hit_cnt !== 16'(exp_hits)) begin
      n_fail++;
      $display("FAIL store_miss_counters: hit=%0d miss=%0d required %0d %0d",
               hit_cnt, miss_cnt, exp_hits, exp_miss);
    end
  endtask

  task automatic test_conflict();
    int m0;
    m0 = exp_miss;
    access(1'b0, 6'h01, 8'h00, int'($urandom_range(0, 2)), 1'b0);
    access(1'b0, 6'h05, 8'h00, int'($urandom_range(0, 2)), 1'b0);
    access(1'b0, 6'h01, 8'h00, int'($urandom_range(0, 2)), 1'b0);
    idle_cycle();
    n_checks++;
    if (miss_cnt !== 16'(m0 + 3)) begin
      n_fail++;
      $display("FAIL conflict_misses: miss=%0d required %0d", miss_cnt, m0 + 3);
    end
  endtask

  task automatic test_reset_in_rmiss();
    @(posedge clock); #1;
    core_if.MemRead  = 1'b1;
    core_if.MemWrite = 1'b0;
    core_if.Address  = 6'h02;
    @(posedge clock); #1;            // now waiting on the fill
    reset           = 1'b1;
    core_if.MemRead = 1'b0;
    @(posedge clock); #1;
    reset              = 1'b0;
    mem_if.mem_ack     = 1'b1;       // late ack, must be ignored
    mem_if.mem_rdata   = 8'hEE;
    #4;
    n_checks++;
    if (mem_if.mem_req !== 1'b0 || core_if.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: req=%b stall=%b required 0 0", mem_if.mem_req, core_if.Stall);
    end
    idle_cycle();
    n_checks++;
    if (mem_if.mem_req !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL late_ack_ignored: req=%b hit=%0d miss=%0d required 0 0 0",
               mem_if.mem_req, hit_cnt, miss_cnt);
    end
    model_clear();
    access(1'b0, 6'h01, 8'h00, 0, 1'b0);  // was cached before reset: must miss
    access(1'b0, 6'h02, 8'h00, 1, 1'b0);  // must not hold the late 0xEE
    idle_cycle();
  endtask

  task automatic test_zero_latency();
    access(1'b0, 6'h0A, 8'h00, 0, 1'b0);  // two stall cycles
    access(1'b0, 6'h0A, 8'h00, 0, 1'b0);
    access(1'b1, 6'h0A, 8'h5A, 0, 1'b0);
    access(1'b0, 6'h0A, 8'h00, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_write_priority();
    access(1'b1, 6'h0A, 8'hA5, 1, 1'b1);  // MemRead and MemWrite together
    access(1'b0, 6'h0A, 8'h00, 0, 1'b0);
    idle_cycle();
    n_checks++;
    if (bmem[10] !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_priority_memory: mem[0A]=%h required A5", bmem[10]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 120; i++) begin
      bit               wr;
      logic [AW-1:0]    a;
      wr = ($urandom_range(0, 9) < 3);
      a  = AW'($urandom_range(0, 15));
      access(wr, a, NBITS'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    n_checks++;
    if (hit_cnt !== 16'(exp_hits) || miss_cnt !== 16'(exp_miss)) begin
      n_fail++;
      $display("FAIL random_counters: hit=%0d miss=%0d required %0d %0d",
               hit_cnt, miss_cnt, exp_hits, exp_miss);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bmem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL memory_image[%0d]: got %h required %h", i, bmem[i], ref_mem[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset             = 1'b1;
    core_if.MemRead   = 1'b0;
    core_if.MemWrite  = 1'b0;
    core_if.Address   = '0;
    core_if.WriteData = '0;
    mem_if.mem_ack    = 1'b0;
    mem_if.mem_rdata  = '0;
    for (int i = 0; i < MSIZE; i++) begin
      bmem[i]    = NBITS'($urandom);
      ref_mem[i] = bmem[i];
    end
    model_clear();

    test_reset();
    test_read_miss_then_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_in_rmiss();
    test_zero_latency();
    test_write_priority();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
